// File: rtl/instr_rom_arbiter_if.sv
// Bus bundle between the instruction ROM arbiter, its two fetch clients
// (CPU and debug readback), the ROM macro and the load/status handshake.
interface instr_rom_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              i_load_done;
    logic [ADDR_W-1:0] i_max_addr;

    logic              i_cpu_req;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic              o_cpu_gnt;
    logic              o_cpu_valid;
    logic [DATA_W-1:0] o_cpu_instr;

    logic              i_dbg_req;
    logic [ADDR_W-1:0] i_dbg_addr;
    logic              o_dbg_gnt;
    logic              o_dbg_valid;
    logic [DATA_W-1:0] o_dbg_instr;

    logic              o_rom_en_read;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [DATA_W-1:0] i_rom_instr;

    logic              o_ready;
    logic              o_addr_err;

    // Arbiter side
    modport slave (
        input  i_load_done, i_max_addr,
        input  i_cpu_req, i_cpu_addr,
        output o_cpu_gnt, o_cpu_valid, o_cpu_instr,
        input  i_dbg_req, i_dbg_addr,
        output o_dbg_gnt, o_dbg_valid, o_dbg_instr,
        output o_rom_en_read, o_rom_addr,
        input  i_rom_instr,
        output o_ready, o_addr_err
    );

    // Client / environment side
    modport master (
        output i_load_done, i_max_addr,
        output i_cpu_req, i_cpu_addr,
        input  o_cpu_gnt, o_cpu_valid, o_cpu_instr,
        output i_dbg_req, i_dbg_addr,
        input  o_dbg_gnt, o_dbg_valid, o_dbg_instr,
        input  o_rom_en_read, o_rom_addr,
        output i_rom_instr,
        input  o_ready, o_addr_err
    );
endinterface

// File: rtl/instr_rom_arbiter.sv
// Two-client (CPU fetch / debug readback) arbiter in front of a synchronous
// instruction ROM. Serves nothing until the ROM load has completed, then one
// read every three cycles with round-robin tie breaking and a range check
// against the programmed top address.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOAD | ROM not loaded yet, all requests ignored
// IDLE      | loaded, waiting for a request; picks and latches a winner
// ISSUE     | grant pulse to winner, ROM read enable if address in range
// RESP      | valid pulse to winner with ROM word (or NOP if out of range)
module instr_rom_arbiter #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0000
) (
    input logic                i_clk,
    input logic                i_rst_n,
    instr_rom_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        WAIT_LOAD,
        IDLE,
        ISSUE,
        RESP
    } state_t;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DBG = 1'b1;

    state_t            state;
    logic              last_win;
    logic              win_q;
    logic              oor_q;

    logic              ready_q;
    logic              cpu_gnt_q;
    logic              dbg_gnt_q;
    logic              cpu_valid_q;
    logic              dbg_valid_q;
    logic              rom_en_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              addr_err_q;

    logic              any_req;
    logic              pick;
    logic [ADDR_W-1:0] pick_addr;
    logic              pick_oor;

    // Round-robin pick: a lone requester always wins, a tie goes to the
    // client that did not win last time.
    always_comb begin
        any_req = bus.i_cpu_req | bus.i_dbg_req;
        pick    = SEL_CPU;
        if (bus.i_cpu_req && bus.i_dbg_req) begin
            pick = (last_win == SEL_DBG) ? SEL_CPU : SEL_DBG;
        end else if (bus.i_dbg_req) begin
            pick = SEL_DBG;
        end
        pick_addr = (pick == SEL_DBG) ? bus.i_dbg_addr : bus.i_cpu_addr;
        pick_oor  = (pick_addr > bus.i_max_addr);
    end

    // Sequencer with registered handshake outputs; pulses default low each cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= WAIT_LOAD;
            last_win    <= SEL_DBG;
            win_q       <= SEL_CPU;
            oor_q       <= 1'b0;
            ready_q     <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            cpu_valid_q <= 1'b0;
            dbg_valid_q <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            cpu_gnt_q   <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            cpu_valid_q <= 1'b0;
            dbg_valid_q <= 1'b0;
            rom_en_q    <= 1'b0;
            addr_err_q  <= 1'b0;
            case (state)
                WAIT_LOAD: begin
                    if (bus.i_load_done) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (any_req) begin
                        win_q     <= pick;
                        oor_q     <= pick_oor;
                        last_win  <= pick;
                        cpu_gnt_q <= (pick == SEL_CPU);
                        dbg_gnt_q <= (pick == SEL_DBG);
                        rom_en_q  <= !pick_oor;
                        if (!pick_oor) begin
                            rom_addr_q <= pick_addr;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cpu_valid_q <= (win_q == SEL_CPU);
                    dbg_valid_q <= (win_q == SEL_DBG);
                    addr_err_q  <= oor_q;
                    state       <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= WAIT_LOAD;
                end
            endcase
        end
    end

    // ROM data only arrives during RESP, so the instruction word is steered
    // combinationally behind the registered valid.
    always_comb begin
        bus.o_cpu_instr = (cpu_valid_q && !oor_q) ? bus.i_rom_instr : NOP_INSTR;
        bus.o_dbg_instr = (dbg_valid_q && !oor_q) ? bus.i_rom_instr : NOP_INSTR;
    end

    assign bus.o_ready       = ready_q;
    assign bus.o_cpu_gnt     = cpu_gnt_q;
    assign bus.o_dbg_gnt     = dbg_gnt_q;
    assign bus.o_cpu_valid   = cpu_valid_q;
    assign bus.o_dbg_valid   = dbg_valid_q;
    assign bus.o_rom_en_read = rom_en_q;
    assign bus.o_rom_addr    = rom_addr_q;
    assign bus.o_addr_err    = addr_err_q;

endmodule

// File: tb/tb_instr_rom_arbiter.sv
// Directed bench for instr_rom_arbiter: a synchronous ROM model, a
// scoreboard of expected transactions and a negedge monitor that checks
// every grant / valid against the head of the scoreboard.
module tb_instr_rom_arbiter;

    localparam logic [15:0] NOP = 16'h0000;

    typedef struct {
        bit          who;   // 0 = CPU, 1 = DBG
        logic [7:0]  addr;
        bit          oor;
        logic [15:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    instr_rom_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    instr_rom_arbiter #(.ADDR_W(8), .DATA_W(16), .NOP_INSTR(NOP)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    logic [15:0] rom_q = '0;
    always @(posedge clk) if (bus.o_rom_en_read) rom_q <= rom[bus.o_rom_addr];
    assign bus.i_rom_instr = rom_q;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   gnt_cyc = 0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Protocol monitor and scoreboard consumer
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("one_gnt", {31'b0, bus.o_cpu_gnt & bus.o_dbg_gnt}, 0);
            check("one_valid", {31'b0, bus.o_cpu_valid & bus.o_dbg_valid}, 0);
            if (!bus.o_cpu_valid) check("cpu_instr_nop", bus.o_cpu_instr, NOP);
            if (!bus.o_dbg_valid) check("dbg_instr_nop", bus.o_dbg_instr, NOP);
            if (bus.o_cpu_gnt || bus.o_dbg_gnt) begin
                if (sb.size() == 0) begin
                    check("unexpected_gnt", 1, 0);
                end else begin
                    check("gnt_who", {31'b0, bus.o_dbg_gnt}, {31'b0, sb[0].who});
                    check("en_read", {31'b0, bus.o_rom_en_read}, {31'b0, !sb[0].oor});
                    if (!sb[0].oor) check("rom_addr", bus.o_rom_addr, sb[0].addr);
                    gnt_cyc = cyc;
                end
            end else begin
                check("en_without_gnt", {31'b0, bus.o_rom_en_read}, 0);
            end
            if (bus.o_cpu_valid || bus.o_dbg_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    check("valid_who", {31'b0, bus.o_dbg_valid}, {31'b0, sb[0].who});
                    check("instr", sb[0].who ? bus.o_dbg_instr : bus.o_cpu_instr, sb[0].instr);
                    check("addr_err", {31'b0, bus.o_addr_err}, {31'b0, sb[0].oor});
                    check("gnt_to_valid", cyc - gnt_cyc, 1);
                    void'(sb.pop_front());
                end
            end else begin
                check("addr_err_idle", {31'b0, bus.o_addr_err}, 0);
            end
        end
    end

    task automatic wait_gnt(input bit who);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (who ? bus.o_dbg_gnt : bus.o_cpu_gnt) return;
        end
        check("gnt_timeout", 1, 0);
    endtask

    task automatic wait_any_gnt();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.o_cpu_gnt || bus.o_dbg_gnt) return;
        end
        check("any_gnt_timeout", 1, 0);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("drain", sb.size(), 0);
    endtask

    function automatic exp_t mk(bit who, logic [7:0] addr, logic [7:0] max);
        exp_t e;
        e.who   = who;
        e.addr  = addr;
        e.oor   = (addr > max);
        e.instr = e.oor ? NOP : rom[addr];
        return e;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'(i * 257) ^ 16'h3C00;
        rom[8'h05] = 16'hA5C3;

        rst_n = 1'b0;
        bus.i_load_done = 1'b0;
        bus.i_max_addr  = 8'h10;
        bus.i_cpu_req   = 1'b0;
        bus.i_cpu_addr  = 8'h00;
        bus.i_dbg_req   = 1'b0;
        bus.i_dbg_addr  = 8'h00;
        #2;
        check("rst_ready", {31'b0, bus.o_ready}, 0);
        check("rst_cpu_gnt", {31'b0, bus.o_cpu_gnt}, 0);
        check("rst_rom_addr", bus.o_rom_addr, 0);
        check("rst_cpu_instr", bus.o_cpu_instr, NOP);
        check("rst_dbg_instr", bus.o_dbg_instr, NOP);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Requests before load are ignored
        bus.i_cpu_req  = 1'b1;
        bus.i_cpu_addr = 8'h05;
        repeat (20) @(negedge clk);
        check("preload_ready", {31'b0, bus.o_ready}, 0);
        sb.push_back('{who: 1'b0, addr: 8'h05, oor: 1'b0, instr: 16'hA5C3});
        bus.i_load_done = 1'b1;
        @(negedge clk);
        check("load_ready", {31'b0, bus.o_ready}, 1);
        check("load_no_gnt_yet", {31'b0, bus.o_cpu_gnt}, 0);
        @(negedge clk);
        check("load_cpu_gnt", {31'b0, bus.o_cpu_gnt}, 1);
        bus.i_cpu_req = 1'b0;
        drain();

        // Loaded status is sticky
        bus.i_load_done = 1'b0;
        repeat (3) @(negedge clk);
        check("ready_sticky", {31'b0, bus.o_ready}, 1);

        // Range boundary on the debug port
        bus.i_dbg_addr = 8'h10;
        sb.push_back(mk(1'b1, 8'h10, 8'h10));
        bus.i_dbg_req = 1'b1;
        wait_gnt(1'b1);
        bus.i_dbg_req = 1'b0;
        drain();
        bus.i_dbg_addr = 8'h11;
        sb.push_back(mk(1'b1, 8'h11, 8'h10));
        bus.i_dbg_req = 1'b1;
        wait_gnt(1'b1);
        bus.i_dbg_req = 1'b0;
        drain();

        // Tie: last winner was DBG, so CPU, DBG, CPU, DBG
        bus.i_cpu_addr = 8'h03;
        bus.i_dbg_addr = 8'h07;
        sb.push_back(mk(1'b0, 8'h03, 8'h10));
        sb.push_back(mk(1'b1, 8'h07, 8'h10));
        sb.push_back(mk(1'b0, 8'h03, 8'h10));
        sb.push_back(mk(1'b1, 8'h07, 8'h10));
        bus.i_cpu_req = 1'b1;
        bus.i_dbg_req = 1'b1;
        for (int n = 0; n < 4; n++) wait_any_gnt();
        bus.i_cpu_req = 1'b0;
        bus.i_dbg_req = 1'b0;
        drain();

        // Debug pulse during a CPU ISSUE is dropped
        bus.i_cpu_addr = 8'h09;
        sb.push_back(mk(1'b0, 8'h09, 8'h10));
        bus.i_cpu_req = 1'b1;
        wait_gnt(1'b0);
        bus.i_cpu_req  = 1'b0;
        bus.i_dbg_addr = 8'h02;
        bus.i_dbg_req  = 1'b1;
        @(negedge clk);
        bus.i_dbg_req = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        // Reset while in ISSUE aborts the read
        bus.i_cpu_addr = 8'h04;
        sb.push_back(mk(1'b0, 8'h04, 8'h10));
        bus.i_cpu_req = 1'b1;
        wait_gnt(1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_cpu_gnt", {31'b0, bus.o_cpu_gnt}, 0);
        check("abort_en_read", {31'b0, bus.o_rom_en_read}, 0);
        check("abort_ready", {31'b0, bus.o_ready}, 0);
        check("abort_rom_addr", bus.o_rom_addr, 0);
        sb.delete();
        bus.i_cpu_req   = 1'b0;
        bus.i_load_done = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerelease_ready", {31'b0, bus.o_ready}, 1);
        repeat (4) @(negedge clk);

        // Service resumes after reset
        bus.i_cpu_addr = 8'h0F;
        sb.push_back(mk(1'b0, 8'h0F, 8'h10));
        bus.i_cpu_req = 1'b1;
        wait_gnt(1'b0);
        bus.i_cpu_req = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
